// File: rtl/mem_if_pkg.sv
// Shared types and sizes for the buffer-memory burst master.
// The buffer is 2K x 16, single port, with one busy cycle after every access.
package mem_if_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrIssue,
        StWrGap,
        StRdIssue,
        StRdWait,
        StRdDrain
    } mbm_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
    } burst_cmd_t;

endpackage

// File: rtl/rd_out_slot.sv
// Single-entry valid/ready holding register for returned read beats.
// Data and last flag are frozen while the entry waits to be consumed.
module rd_out_slot
    import mem_if_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            last_q  <= load_last;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the 2K x 16 buffer: turns burst commands into paced single-word
// accesses, feeding writes from a valid/ready stream and returning reads on another.
module mem_burst_master
    import mem_if_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_output_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    mbm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              cmd_ready_q, wdata_ready_q, busy_q;

    logic              slot_load;
    logic [DATA_W-1:0] slot_data;
    logic              slot_last;
    burst_cmd_t        cmd;

    assign cmd = '{write: cmd_write, addr: cmd_addr, len: cmd_len};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        err_d     = err_q;
        done_d    = 1'b0;
        slot_load = 1'b0;
        slot_data = '0;
        slot_last = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd.addr;
                    rem_d   = cmd.len;
                    err_d   = 1'b0;
                    state_d = cmd.write ? StWrIssue : StRdIssue;
                end
            end
            StWrIssue: begin
                if (wdata_valid) begin
                    mem_wr_en = 1'b1;
                    state_d   = StWrGap;
                    // Registered done lands in the gap cycle after the final write.
                    done_d    = (rem_q == '0);
                end
            end
            StWrGap: begin
                if (rem_q == '0) begin
                    state_d = StIdle;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - ADDR_W'(1);
                    state_d = StWrIssue;
                end
            end
            StRdIssue: begin
                // Only read when the beat has somewhere to land next cycle.
                if (!rdata_valid || rdata_ready) begin
                    mem_rd_en = 1'b1;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                slot_load = 1'b1;
                slot_last = (rem_q == '0);
                if (mem_output_ready) begin
                    slot_data = mem_rdata;
                end else begin
                    err_d = 1'b1;
                end
                if (rem_q == '0) begin
                    state_d = StRdDrain;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - ADDR_W'(1);
                    state_d = StRdIssue;
                end
            end
            StRdDrain: begin
                if (rdata_valid && rdata_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            rem_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            err_q         <= err_d;
            done_q        <= done_d;
            cmd_ready_q   <= (state_d == StIdle);
            wdata_ready_q <= (state_d == StWrIssue);
            busy_q        <= (state_d != StIdle);
        end
    end

    rd_out_slot u_rd_out_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (slot_load),
        .load_data (slot_data),
        .load_last (slot_last),
        .ready     (rdata_ready),
        .valid     (rdata_valid),
        .data      (rdata),
        .last      (rdata_last)
    );

    assign mem_addr    = (mem_wr_en || mem_rd_en) ? addr_q : '0;
    assign mem_wdata   = mem_wr_en ? wdata : '0;
    assign cmd_ready   = cmd_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master with a behavioural buffer-memory model.
module tb_mem_burst_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr, cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [15:0] rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_output_ready;
    logic        busy, done, err;

    mem_burst_master dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .wdata            (wdata),
        .rdata_valid      (rdata_valid),
        .rdata_ready      (rdata_ready),
        .rdata            (rdata),
        .rdata_last       (rdata_last),
        .mem_wr_en        (mem_wr_en),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_output_ready (mem_output_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write lands at the edge, read response valid the following cycle.
    logic [15:0] mem [2048];
    logic        drop_en;
    logic [10:0] drop_addr;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) begin
            mem_rdata        <= mem[mem_addr];
            mem_output_ready <= !(drop_en && mem_addr == drop_addr);
        end else begin
            mem_output_ready <= 1'b0;
        end
    end

    // Protocol monitor: request spacing and output-slot stability.
    int          proto_viol = 0;
    int          stab_viol  = 0;
    logic        prev_req   = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (mem_wr_en && mem_rd_en) proto_viol++;
            if ((mem_wr_en || mem_rd_en) && prev_req) proto_viol++;
            if (prev_hold && (!rdata_valid || rdata != prev_data || rdata_last != prev_last))
                stab_viol++;
            prev_req  = mem_wr_en || mem_rd_en;
            prev_hold = rdata_valid && !rdata_ready;
            prev_data = rdata;
            prev_last = rdata_last;
        end
    end

    typedef struct {
        logic             write;
        logic [10:0]      addr;
        logic [10:0]      len;
        logic [3:0][15:0] data;     // write data, or expected read data
        logic [3:0][10:0] exp_addr;
        int               exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-burst observations, relative to the command-accept cycle.
    int          n_req, n_beat, done_cyc, done_cnt, rst_rel;
    int          req_cyc [8];
    logic [10:0] req_addr [8];
    logic [15:0] req_data [8];
    int          beat_cyc [8];
    logic [15:0] beat_data [8];
    logic        beat_last [8];
    logic        err_at_done, err_rel1, ready_after;
    logic [51:0] rst_outs;

    task automatic run_burst(input vec_t v, input int hold_until, input int stall_lo,
                             input int stall_hi, input int rst_at, input int max_cyc);
        int   rel;
        int   k;
        bit   acc;
        logic hs;
        n_req = 0; n_beat = 0; done_cyc = -1; done_cnt = 0; rst_rel = -1;
        err_at_done = 1'bx; err_rel1 = 1'bx; ready_after = 1'b0; rst_outs = '1;
        for (int i = 0; i < 8; i++) begin
            req_cyc[i] = -1; beat_cyc[i] = -1; req_addr[i] = 'x;
            req_data[i] = 'x; beat_data[i] = 'x; beat_last[i] = 1'bx;
        end
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
        k = 0; wdata = v.data[0]; wdata_valid = v.write;
        rdata_ready = (hold_until == 0);
        acc = 1'b0; rel = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (acc) rel++;
            else if (cmd_valid && cmd_ready) begin acc = 1'b1; rel = 0; end
            if (acc && !reset_n) begin
                rst_rel  = rel;
                rst_outs = {cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, mem_wr_en,
                            mem_rd_en, mem_addr, mem_wdata, busy, done, err};
                break;
            end
            if (acc) begin
                if ((mem_wr_en || mem_rd_en) && n_req < 8) begin
                    req_cyc[n_req] = rel; req_addr[n_req] = mem_addr;
                    req_data[n_req] = mem_wdata; n_req++;
                end
                if (rdata_valid && rdata_ready && n_beat < 8) begin
                    beat_cyc[n_beat] = rel; beat_data[n_beat] = rdata;
                    beat_last[n_beat] = rdata_last; n_beat++;
                end
                if (done) begin
                    done_cnt++;
                    if (done_cyc < 0) begin done_cyc = rel; err_at_done = err; end
                end
                if (rel == 1) err_rel1 = err;
                if (done_cyc >= 0 && rel == done_cyc + 1) begin
                    ready_after = cmd_ready;
                    break;
                end
            end
            hs = wdata_valid && wdata_ready;
            @(posedge clk); #1;
            if (acc) cmd_valid = 1'b0;
            if (hs) k++;
            wdata = v.data[(k <= 3) ? k : 0];
            wdata_valid = v.write && (k <= int'(v.len)) &&
                          !(acc && rel + 1 >= stall_lo && rel + 1 <= stall_hi);
            rdata_ready = acc ? (rel + 1 >= hold_until) : (hold_until == 0);
            if (acc && rel + 1 == rst_at) reset_n = 1'b0;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [4];
    vec_t v;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        drop_en = 1'b0; drop_addr = 11'h7FF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, mem_wr_en,
                              mem_rd_en, mem_addr, mem_wdata, busy, done, err}, 52'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        vecs[0] = '{write: 1'b1, addr: 11'h010, len: 11'd3,
                    data: {16'hA004, 16'hA003, 16'hA002, 16'hA001},
                    exp_addr: {11'h013, 11'h012, 11'h011, 11'h010}, exp_done: 8};
        vecs[1] = '{write: 1'b0, addr: 11'h010, len: 11'd3,
                    data: {16'hA004, 16'hA003, 16'hA002, 16'hA001},
                    exp_addr: {11'h013, 11'h012, 11'h011, 11'h010}, exp_done: 10};
        vecs[2] = '{write: 1'b1, addr: 11'h7FE, len: 11'd3,
                    data: {16'hB004, 16'hB003, 16'hB002, 16'hB001},
                    exp_addr: {11'h001, 11'h000, 11'h7FF, 11'h7FE}, exp_done: 8};
        vecs[3] = '{write: 1'b0, addr: 11'h7FE, len: 11'd3,
                    data: {16'hB004, 16'hB003, 16'hB002, 16'hB001},
                    exp_addr: {11'h001, 11'h000, 11'h7FF, 11'h7FE}, exp_done: 10};

        for (int vi = 0; vi < 4; vi++) begin
            run_burst(vecs[vi], 0, -1, -1, -1, 40);
            chk($sformatf("v%0d_nreq", vi), n_req, 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_req%0d_cyc", vi, i), req_cyc[i], 1 + 2 * i);
                chk($sformatf("v%0d_req%0d_addr", vi, i), req_addr[i], vecs[vi].exp_addr[i]);
                if (vecs[vi].write) begin
                    chk($sformatf("v%0d_req%0d_wdata", vi, i), req_data[i], vecs[vi].data[i]);
                end else begin
                    chk($sformatf("v%0d_beat%0d_cyc", vi, i), beat_cyc[i], 3 + 2 * i);
                    chk($sformatf("v%0d_beat%0d_data", vi, i), beat_data[i], vecs[vi].data[i]);
                    chk($sformatf("v%0d_beat%0d_last", vi, i), beat_last[i], i == 3);
                end
            end
            if (!vecs[vi].write) begin
                chk($sformatf("v%0d_nbeat", vi), n_beat, 4);
                chk($sformatf("v%0d_err", vi), err_at_done, 0);
            end
            chk($sformatf("v%0d_done_cyc", vi), done_cyc, vecs[vi].exp_done);
            chk($sformatf("v%0d_done_cnt", vi), done_cnt, 1);
            chk($sformatf("v%0d_cmd_ready_after", vi), ready_after, 1);
        end

        // Backpressure: consumer stalls for 10 cycles, then reads resume one per consume.
        v = '{write: 1'b0, addr: 11'h010, len: 11'd2,
              data: {16'h0000, 16'hA003, 16'hA002, 16'hA001},
              exp_addr: {11'h000, 11'h012, 11'h011, 11'h010}, exp_done: 15};
        run_burst(v, 10, -1, -1, -1, 60);
        chk("bp_nreq", n_req, 3);
        chk("bp_req0_cyc", req_cyc[0], 1);
        chk("bp_req1_cyc", req_cyc[1], 10);
        chk("bp_req2_cyc", req_cyc[2], 12);
        chk("bp_req2_addr", req_addr[2], 11'h012);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_beat%0d_cyc", i), beat_cyc[i], 10 + 2 * i);
            chk($sformatf("bp_beat%0d_data", i), beat_data[i], v.data[i]);
            chk($sformatf("bp_beat%0d_last", i), beat_last[i], i == 2);
        end
        chk("bp_done_cyc", done_cyc, v.exp_done);

        // Missing response on the second read of the wrapping burst.
        drop_en = 1'b1;
        v = '{write: 1'b0, addr: 11'h7FE, len: 11'd3,
              data: {16'hB004, 16'hB003, 16'h0000, 16'hB001},
              exp_addr: {11'h001, 11'h000, 11'h7FF, 11'h7FE}, exp_done: 10};
        run_burst(v, 0, -1, -1, -1, 40);
        drop_en = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("miss_beat%0d_data", i), beat_data[i], v.data[i]);
        chk("miss_err_at_done", err_at_done, 1);
        chk("miss_done_cyc", done_cyc, 10);
        chk("miss_err_sticky", err, 1);

        v = '{write: 1'b0, addr: 11'h010, len: 11'd0,
              data: {16'h0000, 16'h0000, 16'h0000, 16'hA001},
              exp_addr: {11'h000, 11'h000, 11'h000, 11'h010}, exp_done: 4};
        run_burst(v, 0, -1, -1, -1, 30);
        chk("clear_err_rel1", err_rel1, 0);
        chk("clear_beat0_data", beat_data[0], 16'hA001);
        chk("clear_beat0_last", beat_last[0], 1);
        chk("clear_done_cyc", done_cyc, 4);

        // Write stall of 5 cycles, then reset lands in the final gap cycle.
        v = '{write: 1'b1, addr: 11'h100, len: 11'd1,
              data: {16'h0000, 16'h0000, 16'hC002, 16'hC001},
              exp_addr: {11'h000, 11'h000, 11'h101, 11'h100}, exp_done: 9};
        run_burst(v, 0, 3, 7, 9, 40);
        chk("stall_nreq", n_req, 2);
        chk("stall_req0_cyc", req_cyc[0], 1);
        chk("stall_req1_cyc", req_cyc[1], 8);
        chk("stall_req1_addr", req_addr[1], 11'h101);
        chk("stall_req1_wdata", req_data[1], 16'hC002);
        chk("rst_seen_cyc", rst_rel, 9);
        chk("rst_outputs", rst_outs, 52'd0);
        chk("rst_no_done", done_cnt, 0);
        @(negedge clk);
        chk("rst_cmd_ready_low", cmd_ready, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready_after", cmd_ready, 1);
        chk("rst_busy_after", busy, 0);

        chk("proto_spacing", proto_viol, 0);
        chk("slot_stability", stab_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for the 2K x 16 single-port buffer memory in the neural engine datapath. Accepts burst commands (start address, length, direction) and converts them into correctly paced single-word `wr_en`/`rd_en` accesses. Each access honours the memory's busy cycle. Write data is taken from a valid/ready stream, and read data is returned on a valid/ready stream with a last flag.

## Interface
- `ADDR_W`, 11: memory address width; 2^ADDR_W words.
- `DATA_W`, 16: memory word width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in ADDR_W: word count minus 1 (0 → 1 word, 2047 → 2048 words).
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in DATA_W: write stream.
- `rdata_valid` out 1, `rdata_ready` in 1, `rdata` out DATA_W, `rdata_last` out 1: read stream.
- `mem_wr_en` out 1, `mem_rd_en` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory request port.
- `mem_rdata` in DATA_W, `mem_output_ready` in 1: memory response port.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse at burst completion.
- `err` out 1: sticky read-response error.

## Operation
- States:
  - IDLE: `cmd_ready=1`. On `cmd_valid`, latch `addr`, `remaining=cmd_len`, `dir`, and clear `err`. Go to WR_ISSUE or RD_ISSUE.
  - WR_ISSUE: `wdata_ready=1`.
    - If `wdata_valid`: `mem_wr_en=1`, `mem_wdata=wdata`, `mem_addr=addr`, then go to WR_GAP.
    - Else stay in WR_ISSUE.
  - WR_GAP: memory busy; no request. If `remaining==0`, pulse `done` and go to IDLE. Else `addr+1`, `remaining-1`, and go to WR_ISSUE.
  - RD_ISSUE: issue `mem_rd_en=1` with `mem_addr=addr` only when the output slot is empty, or full and consumed this cycle (`rdata_valid && rdata_ready`). Then go to RD_WAIT.
  - RD_WAIT: `mem_output_ready` must be 1 this cycle.
    - Load the slot: `rdata=mem_rdata`, `rdata_valid=1`, `rdata_last=(remaining==0)`.
    - If `mem_output_ready=0`, set `err` and load `rdata=0` (the beat is still delivered).
    - If `remaining==0`, go to RD_DRAIN. Else `addr+1`, `remaining-1`, and go to RD_ISSUE.
  - RD_DRAIN: wait for the last beat to be consumed; that cycle pulse `done` and go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; address 2047 wraps to 0 within a burst.
- Output slot holds one entry. `rdata_valid` stays high until `rdata_ready`, and `rdata`/`rdata_last` are stable while it is held.
- `mem_wr_en` and `mem_rd_en` are never high together, and never high in two consecutive cycles.
- `wdata_ready` is high only in WR_ISSUE; extra write beats outside a burst are not consumed.
- Reset values: `cmd_ready=0` during reset (1 after), `wdata_ready=0`, `rdata_valid=0`, `rdata=0`, `rdata_last=0`, all `mem_*` outputs 0, `busy=0`, `done=0`, `err=0`, state IDLE.
- Reset mid-burst aborts immediately. The in-flight slot is discarded and no `done` is produced.

## Timing
- Memory contract:
  - Write accepted at cycle t; memory idle at t+2.
  - Read accepted at t; `mem_output_ready`/`mem_rdata` valid at t+1; memory idle at t+2.
- Peak throughput: 1 word per 2 cycles in both directions.
- Command accept to first `mem_wr_en`/`mem_rd_en`: 1 cycle (from entry to the ISSUE state), given data or slot availability.
- Read: `rdata_valid` rises at t+2 relative to `mem_rd_en` at t.
- Write `done` pulses in the WR_GAP cycle following the final `mem_wr_en`.
- `mem_*` request outputs are combinational from registered state, registered `addr`, and the `wdata`/`wdata_valid` handshake. All other outputs are registered.

## Structure
- Shared package `mem_if_pkg`:
  - `ADDR_W`, `DATA_W`.
  - State enum `mbm_state_t` (IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_WAIT, RD_DRAIN).
  - Burst command struct (write, addr, len).
- One natural sub-module: `rd_out_slot`, the single-entry valid/ready holding register for `rdata`/`rdata_last`.
- The FSM and address/remaining counters stay in the top.

## Test plan
- Write burst: `cmd_addr=0x010`, `cmd_len=3`, `wdata` 0xA001..0xA004 always valid.
  - Required: `mem_wr_en` at cycles 1, 3, 5, 7 with addresses 0x010..0x013.
  - Required: `done` pulse in cycle 8 and `cmd_ready` high in cycle 9.
- Read back the same range with `rdata_ready=1`.
  - Required: `rdata` 0xA001..0xA004, `rdata_last` on the 4th beat only, `err=0`.
- Wrap-around: write `cmd_addr=0x7FE`, `cmd_len=3`.
  - Required: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Backpressure: read `len=2` with `rdata_ready=0` for 10 cycles.
  - Required: exactly one `mem_rd_en` issued, `rdata_valid` held with stable data.
  - Required: after release, the remaining reads are issued one per beat consumed.
- Missing response: the model withholds `mem_output_ready` on the 2nd read.
  - Required: `err=1` and that beat has `rdata=0x0000`.
  - Required: `err` clears on the next command accept.
- Write stall and reset: `wdata_valid` low for 5 cycles mid-burst, then `reset_n` asserted during WR_GAP.
  - Required: no `mem_wr_en` during the stall.
  - Required: all outputs at their reset values while reset is asserted, and no `done`.
